// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Purpose : default 640x480@60 timing constants, the totals and sync windows
//           derived from them, and a helper that sums one axis's segments.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
    localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Purpose : bundles the pixel clock enable and the timing outputs.
// Signals : ce (enable into the generator), x, y (positions), hsync, vsync
//           (active low), display_on, line_start, frame_start (pulses).
// Modports: master = timing generator, slave = consumer of the timing.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic             ce;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             hsync;
    logic             vsync;
    logic             display_on;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  ce,
        output x, y, hsync, vsync, display_on, line_start, frame_start
    );

    modport slave (
        output ce,
        input  x, y, hsync, vsync, display_on, line_start, frame_start
    );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// Purpose : one timing axis (horizontal or vertical). Counts 0..TOTAL-1 when
//           advanced, and registers the sync/active flags from the next count
//           so they line up with the registered count.
// Ports   : clk, rst (async, active high), adv_i (advance this edge),
//           count_o (position), wrap_o (count is at its last value, so an
//           advance returns it to 0), sync_n_o (active-low sync),
//           active_o (position inside the visible region).
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_o,
    output logic             sync_n_o,
    output logic             active_o
);

    localparam int               TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sync_n_q, active_q;

    assign wrap_o = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (adv_i) begin
            count_d = wrap_o ? '0 : count_q + CNT_W'(1);
        end
    end

    // Flags are decoded from count_d so they change on the same edge as the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            sync_n_q <= 1'b1;
            active_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            sync_n_q <= !((count_d >= SYNC_START) && (count_d < SYNC_END));
            active_q <= (count_d < ACT_END);
        end
    end

    assign count_o  = count_q;
    assign sync_n_o = sync_n_q;
    assign active_o = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Purpose : VGA raster timing generator. A horizontal axis counter advances on
//           every enabled pixel clock; the vertical one advances when the
//           horizontal axis wraps. Emits positions, active-low syncs,
//           display enable and one-clock line/frame start pulses.
// Ports   : clk, rst (async, active high), bus (vga_timing_gen_if.master:
//           ce in; x, y, hsync, vsync, display_on, line_start, frame_start out).
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  bus
);

    // Counters are CNT_W bits wide; a longer axis would silently alias.
    if (axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP) > (1 << CNT_W)) begin : g_h_too_long
        $error("vga_timing_gen: horizontal total exceeds 1024");
    end
    if (axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP) > (1 << CNT_W)) begin : g_v_too_long
        $error("vga_timing_gen: vertical total exceeds 1024");
    end

    logic             h_wrap, v_wrap;
    logic             h_sync_n, v_sync_n;
    logic             h_active, v_active;
    logic [CNT_W-1:0] h_count, v_count;
    logic             v_adv;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    assign v_adv = bus.ce & h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h (
        .clk      (clk),
        .rst      (rst),
        .adv_i    (bus.ce),
        .count_o  (h_count),
        .wrap_o   (h_wrap),
        .sync_n_o (h_sync_n),
        .active_o (h_active)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v (
        .clk      (clk),
        .rst      (rst),
        .adv_i    (v_adv),
        .count_o  (v_count),
        .wrap_o   (v_wrap),
        .sync_n_o (v_sync_n),
        .active_o (v_active)
    );

    // Pulses mark the edge on which x (and for frames, y) returns to 0.
    assign line_start_d  = bus.ce & h_wrap;
    assign frame_start_d = bus.ce & h_wrap & v_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.x           = h_count;
    assign bus.y           = v_count;
    assign bus.hsync       = h_sync_n;
    assign bus.vsync       = v_sync_n;
    assign bus.display_on  = h_active & v_active;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 clk  input  1  pixel-domain clock; reset rst, asynchronous, active-high; clock clk.
REQ-010 rst  input  1  asynchronous active-high reset.
REQ-011 ce  input  1  pixel clock enable; counters advance only on clk edges where ce=1.
REQ-012 x  output  10  current horizontal position, 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
REQ-013 y  output  10  current vertical position, 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-014 hsync  output  1  horizontal sync, active low.
REQ-015 vsync  output  1  vertical sync, active low.
REQ-016 display_on  output  1  high when x<H_ACTIVE and y<V_ACTIVE.
REQ-017 line_start  output  1  one-clk pulse in the cycle x changes to 0.
REQ-018 frame_start  output  1  one-clk pulse in the cycle (x,y) changes to (0,0).

Function
REQ-019 On a clk edge with ce=1, x shall increment by 1; at x=H_TOTAL-1, x shall wrap to 0.
REQ-020 When x wraps, y shall increment by 1 in the same edge; at y=V_TOTAL-1, y shall wrap to 0.
REQ-021 With ce=0, x, y, hsync, vsync and display_on shall hold, and line_start and frame_start shall be 0.
REQ-022 hsync, vsync and display_on shall be registered from the next-state counter values, so they are always consistent with the registered x/y (zero relative latency).
REQ-023 hsync shall be 0 exactly when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751 by default), and 1 otherwise.
REQ-024 vsync shall be 0 exactly when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491 by default), for all x in those lines, and 1 otherwise.
REQ-025 vsync rising edge shall occur on the edge where y changes from 491 to 492 with x changing to 0; consumers use this edge as the frame tick.
REQ-026 line_start and frame_start shall be registered pulses, high for exactly one clk.
REQ-027 line_start and frame_start shall be asserted only on ce=1 edges.
REQ-028 Counter arithmetic shall be 10-bit unsigned; comparisons shall be against parameter-derived constants; no counter value outside its range shall ever appear.
REQ-029 Elaboration shall fail if H_TOTAL>1024 or V_TOTAL>1024.

Reset
REQ-030 While rst=1, outputs shall be: x=0, y=0, hsync=1, vsync=1, display_on=1, line_start=0, frame_start=0.
REQ-031 The first ce=1 edge after rst deasserts shall move to x=1, y=0 with no start pulses.
REQ-032 Reset asserted mid-frame shall immediately restore the REQ-030 values; no partial line is completed.

Structure
REQ-033 Package vga_timing_pkg shall hold the default timing constants and the derived H_TOTAL/V_TOTAL and sync start/end values.
REQ-034 One sub-module, vga_axis_counter, parameterised by active/fp/sync/bp, shall be instantiated twice:
- horizontal instance, advanced by ce;
- vertical instance, advanced by ce AND the horizontal wrap.
REQ-035 The sub-module shall provide count, wrap, sync_n and active.

Verification
REQ-036 Reset, then ce=1 continuously for 420000 clks:
- exactly one frame_start, at clk 420000;
- 525 line_start pulses;
- display_on high for exactly 307200 clks.
REQ-037 Per line, with ce=1: hsync falls on the edge to x=656, rises on the edge to x=752, and stays low for exactly 96 clks.
REQ-038 vsync falls on the edge to (x=0, y=490), rises on the edge to (x=0, y=492), and stays low for exactly 1600 clks.
REQ-039 ce toggled 1,0,1,0 from reset (ce high every other clk): full frame takes 840000 clks; x/y hold on ce=0 clks; no pulses on ce=0 clks.
REQ-040 rst pulsed for 1 clk at (x=300, y=200) -> outputs match REQ-030 asynchronously; the next frame_start occurs after 420000 ce cycles.
REQ-041 Wrap corner: at (x=799, y=524) with ce=1 -> next edge gives x=0, y=0, frame_start=1, line_start=1, display_on=1.
